// File: rtl/cps2_timing_pkg.sv
// Shared timing definitions for the scan-converter output raster.
//
// Holds the lock FSM state encoding, the default line-buffer ring depth,
// the CPS2 source raster dimensions, and a helper that measures the
// circular distance between two line numbers.
package cps2_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } lbuf_state_e;

  localparam int NUM_LINE_BUFFERS_DEF = 40;

  localparam int CPS2_SRC_H_ACTIVE = 384;
  localparam int CPS2_SRC_V_ACTIVE = 224;

  // Shortest distance between lines a and b on a raster of m lines.
  // a + m - b may overflow 11 bits, but the true result is < m, so the
  // modular wrap of the intermediate sum is harmless.
  function automatic logic [10:0] ring_dist(input logic [10:0] a,
                                            input logic [10:0] b,
                                            input logic [10:0] m);
    logic [10:0] d;
    d = (a >= b) ? (a - b) : (a + m - b);
    return (d <= (m - d)) ? d : (m - d);
  endfunction

endpackage

// File: rtl/lbuf_readout_ctrl_rep_counter.sv
// rep_counter: replication index plus read-address counter.
//
// The replica index cycles 0..MULT-1 on each step; the address advances
// when the index rolls over and wraps from ADDR_WRAP-1 back to 0.
// clear_i has priority over step_i and forces both counts to 0.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clear_i  synchronous clear of index and address
//   step_i   advance by one replica position
//   ctr_o    replica index
//   addr_o   read address
module rep_counter
  import cps2_timing_pkg::*;
#(
  parameter int MULT      = 2,
  parameter int CTR_W     = 3,
  parameter int ADDR_W    = 9,
  parameter int ADDR_WRAP = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [CTR_W-1:0]  ctr_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(MULT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_WRAP - 1);

  logic [CTR_W-1:0]  ctr_q,  ctr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    ctr_d  = ctr_q;
    addr_d = addr_q;
    if (clear_i) begin
      ctr_d  = '0;
      addr_d = '0;
    end else if (step_i) begin
      if (ctr_q == CTR_LAST) begin
        ctr_d  = '0;
        addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q  <= '0;
      addr_q <= '0;
    end else begin
      ctr_q  <= ctr_d;
      addr_q <= addr_d;
    end
  end

  assign ctr_o  = ctr_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/lbuf_readout_ctrl.sv
// lbuf_readout_ctrl: output raster timing generator and line-buffer read
// sequencer for the scan converter.
//
// Stage 0 (counters): hcnt/vcnt raster position, line-buffer read column
// and line, horizontal/vertical replica indices.
// Stage 1 (strobes): HSYNC/VSYNC/DE/mask for the stage-0 position of the
// previous clock, lining up with the one-clock line-buffer read latency.
//
// Build option FRAMELOCK_EN:
//   defined   - raster waits for frame_start, then tracks it, forcing
//               vcnt back to V_LOCK_LINE when the error exceeds LOCK_WIN.
//   undefined - frame_start is ignored; raster free-runs from reset and
//               reports locked=1 permanently.
//
// State table:
//   state     | meaning
//   ST_IDLE   | counters held at 0, strobes inactive, waiting to start
//   ST_RUN    | raster running, not (yet) in lock with the input frame
//   ST_LOCKED | raster running and frame_start lands inside LOCK_WIN
//
// Ports:
//   PCLK_in          output pixel clock
//   reset_n          asynchronous active-low reset
//   frame_start      input frame start pulse (PCLK_in domain)
//   hcnt_ext/vcnt_ext         raster counters
//   hcnt_ext_lbuf/vcnt_ext_lbuf  line-buffer read column / line
//   hctr_ext/vctr_ext         horizontal / vertical replica index
//   HSYNC_ext/VSYNC_ext       active-low syncs
//   DE_ext           data enable
//   mask_enable_ext  DE outside the source window
//   locked           raster running and in lock
//   resync           one-clock pulse when vcnt was forced
module lbuf_readout_ctrl
  import cps2_timing_pkg::*;
#(
  parameter int H_TOTAL          = 1056,
  parameter int H_SYNCLEN        = 128,
  parameter int H_BACKPORCH      = 88,
  parameter int H_ACTIVE         = 800,
  parameter int V_TOTAL          = 628,
  parameter int V_SYNCLEN        = 4,
  parameter int V_BACKPORCH      = 23,
  parameter int V_ACTIVE         = 600,
  parameter int SRC_H_ACTIVE     = CPS2_SRC_H_ACTIVE,
  parameter int SRC_V_ACTIVE     = CPS2_SRC_V_ACTIVE,
  parameter int H_MULT           = 2,
  parameter int V_MULT           = 2,
  parameter int NUM_LINE_BUFFERS = NUM_LINE_BUFFERS_DEF,
  parameter int V_LOCK_LINE      = 0,
  parameter int LOCK_WIN         = 2
) (
  input  logic        PCLK_in,
  input  logic        reset_n,
  input  logic        frame_start,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        mask_enable_ext,
  output logic        locked,
  output logic        resync
);

  localparam int H_WIN = SRC_H_ACTIVE * H_MULT;
  localparam int V_WIN = SRC_V_ACTIVE * V_MULT;
  localparam int HS    = H_SYNCLEN + H_BACKPORCH + (H_ACTIVE - H_WIN) / 2;
  localparam int VS    = V_SYNCLEN + V_BACKPORCH + (V_ACTIVE - V_WIN) / 2;

  localparam logic [10:0] HT_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] VT_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNCLEN);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNCLEN);
  localparam logic [10:0] H_DE_BEG   = 11'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [10:0] H_DE_END   = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [10:0] V_DE_BEG   = 11'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [10:0] V_DE_END   = 11'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [10:0] H_WIN_BEG  = 11'(HS);
  localparam logic [10:0] H_WIN_END  = 11'(HS + H_WIN);
  localparam logic [10:0] V_WIN_BEG  = 11'(VS);
  localparam logic [10:0] V_WIN_END  = 11'(VS + V_WIN);
  localparam logic [10:0] V_LOCK     = 11'(V_LOCK_LINE);
`ifdef FRAMELOCK_EN
  localparam logic [10:0] V_TOT      = 11'(V_TOTAL);
  localparam logic [10:0] LOCK_W     = 11'(LOCK_WIN);
`endif

  lbuf_state_e state_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        hsync_q, vsync_q, de_q, mask_q, locked_q, resync_q;

  logic running;
  logic jump;       // counters loaded with (0, V_LOCK_LINE) this clock
  logic fs_force;   // jump that counts as a resync
  logic line_wrap;
  logic h_clr, h_step, v_clr, v_step;
  logic h_de, v_de, h_win, v_win;
`ifdef FRAMELOCK_EN
  logic lock_hit;
`else
  logic [11:0] unused_cfg;
  assign unused_cfg = {frame_start, 11'(LOCK_WIN)};
`endif

  always_comb begin
    running = (state_q != ST_IDLE);
`ifdef FRAMELOCK_EN
    lock_hit = ring_dist(vcnt_q, V_LOCK, V_TOT) <= LOCK_W;
    jump     = frame_start && (!running || !lock_hit);
    fs_force = frame_start && running && !lock_hit;
`else
    jump     = 1'b0;
    fs_force = 1'b0;
`endif

    // A forced load takes priority over the normal wrap.
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    line_wrap = 1'b0;
    if (jump) begin
      hcnt_d = '0;
      vcnt_d = V_LOCK;
    end else if (running) begin
      if (hcnt_q == HT_LAST) begin
        hcnt_d    = '0;
        line_wrap = 1'b1;
        vcnt_d    = (vcnt_q == VT_LAST) ? '0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end

    // Replica counters are registered alongside hcnt/vcnt, so their
    // control is decoded from the next raster position.
    h_clr  = (hcnt_d < H_WIN_BEG) || (hcnt_d >= H_WIN_END) || (hcnt_d == H_WIN_BEG);
    h_step = !h_clr;
    v_clr  = jump || (vcnt_d < V_WIN_BEG) || (vcnt_d >= V_WIN_END) || (vcnt_d == V_WIN_BEG);
    v_step = line_wrap && !v_clr;

    h_de  = (hcnt_q >= H_DE_BEG)  && (hcnt_q < H_DE_END);
    v_de  = (vcnt_q >= V_DE_BEG)  && (vcnt_q < V_DE_END);
    h_win = (hcnt_q >= H_WIN_BEG) && (hcnt_q < H_WIN_END);
    v_win = (vcnt_q >= V_WIN_BEG) && (vcnt_q < V_WIN_END);
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      mask_q   <= 1'b0;
      locked_q <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      resync_q <= fs_force;

`ifdef FRAMELOCK_EN
      case (state_q)
        ST_IDLE: begin
          if (frame_start) state_q <= ST_RUN;
          locked_q <= 1'b0;
        end
        ST_RUN: begin
          if (frame_start && lock_hit) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (frame_start && !lock_hit) begin
            state_q  <= ST_RUN;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
`else
      state_q  <= ST_LOCKED;
      locked_q <= 1'b1;
`endif

      // Strobes for the position the counters held during this clock.
      hsync_q <= !(running && (hcnt_q < H_SYNC_END));
      vsync_q <= !(running && (vcnt_q < V_SYNC_END));
      de_q    <= running && h_de && v_de;
      mask_q  <= running && h_de && v_de && !(h_win && v_win);
    end
  end

  rep_counter #(
    .MULT      (H_MULT),
    .CTR_W     (3),
    .ADDR_W    (9),
    .ADDR_WRAP (SRC_H_ACTIVE)
  ) u_hrep (
    .clk_i   (PCLK_in),
    .rst_ni  (reset_n),
    .clear_i (h_clr),
    .step_i  (h_step),
    .ctr_o   (hctr_ext),
    .addr_o  (hcnt_ext_lbuf)
  );

  rep_counter #(
    .MULT      (V_MULT),
    .CTR_W     (3),
    .ADDR_W    (6),
    .ADDR_WRAP (NUM_LINE_BUFFERS)
  ) u_vrep (
    .clk_i   (PCLK_in),
    .rst_ni  (reset_n),
    .clear_i (v_clr),
    .step_i  (v_step),
    .ctr_o   (vctr_ext),
    .addr_o  (vcnt_ext_lbuf)
  );

  assign hcnt_ext        = hcnt_q;
  assign vcnt_ext        = vcnt_q;
  assign HSYNC_ext       = hsync_q;
  assign VSYNC_ext       = vsync_q;
  assign DE_ext          = de_q;
  assign mask_enable_ext = mask_q;
  assign locked          = locked_q;
  assign resync          = resync_q;

endmodule

// File: tb/tb_lbuf_readout_ctrl.sv
// Testbench for lbuf_readout_ctrl on a reduced raster so that several full
// frames fit in a short run. Expected outputs come from a position-based
// reference model: raster position (h, v), replica indices from division
// and modulo on the window offsets, strobes from the previous position.
module tb_lbuf_readout_ctrl;

  localparam int HT  = 60;
  localparam int HSY = 6;
  localparam int HBP = 5;
  localparam int HA  = 44;
  localparam int VT  = 50;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int VA  = 40;
  localparam int SH  = 20;
  localparam int SV  = 12;
  localparam int HM  = 2;
  localparam int VM  = 3;
  localparam int NLB = 5;
  localparam int VL  = 0;
  localparam int LW  = 2;

  localparam int HWIN  = SH * HM;
  localparam int VWIN  = SV * VM;
  localparam int HS    = HSY + HBP + (HA - HWIN) / 2;
  localparam int VS    = VSY + VBP + (VA - VWIN) / 2;
  localparam int FRAME = HT * VT;

  logic        clk_sys;
  logic        reset_n;
  logic        frame_start;
  logic [10:0] hcnt_ext, vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext, vctr_ext;
  logic        HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked, resync;

  lbuf_readout_ctrl #(
    .H_TOTAL(HT), .H_SYNCLEN(HSY), .H_BACKPORCH(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNCLEN(VSY), .V_BACKPORCH(VBP), .V_ACTIVE(VA),
    .SRC_H_ACTIVE(SH), .SRC_V_ACTIVE(SV), .H_MULT(HM), .V_MULT(VM),
    .NUM_LINE_BUFFERS(NLB), .V_LOCK_LINE(VL), .LOCK_WIN(LW)
  ) dut (
    .PCLK_in         (clk_sys),
    .reset_n         (reset_n),
    .frame_start     (frame_start),
    .hcnt_ext        (hcnt_ext),
    .vcnt_ext        (vcnt_ext),
    .hcnt_ext_lbuf   (hcnt_ext_lbuf),
    .vcnt_ext_lbuf   (vcnt_ext_lbuf),
    .hctr_ext        (hctr_ext),
    .vctr_ext        (vctr_ext),
    .HSYNC_ext       (HSYNC_ext),
    .VSYNC_ext       (VSYNC_ext),
    .DE_ext          (DE_ext),
    .mask_enable_ext (mask_enable_ext),
    .locked          (locked),
    .resync          (resync)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 idle, 1 running unlocked, 2 locked
  int m_state, m_h, m_v, m_hp, m_vp;
  bit m_prev_run, m_resync;
  bit fs_prev;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic bit in_hw(int h); return (h >= HS) && (h < HS + HWIN); endfunction
  function automatic bit in_vw(int v); return (v >= VS) && (v < VS + VWIN); endfunction
  function automatic bit in_hde(int h); return (h >= HSY + HBP) && (h < HSY + HBP + HA); endfunction
  function automatic bit in_vde(int v); return (v >= VSY + VBP) && (v < VSY + VBP + VA); endfunction

  function automatic int lock_err(int v);
    int d;
    d = (v - VL + VT) % VT;
    return (d < VT - d) ? d : VT - d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_h = 0; m_v = 0; m_hp = 0; m_vp = 0;
    m_prev_run = 0; m_resync = 0;
  endtask

  task automatic advance();
    m_h++;
    if (m_h == HT) begin
      m_h = 0;
      m_v = (m_v + 1) % VT;
    end
  endtask

  task automatic model_clock(input bit fs);
    m_prev_run = (m_state != 0);
    m_hp = m_h;
    m_vp = m_v;
    m_resync = 0;
`ifdef FRAMELOCK_EN
    if (m_state == 0) begin
      if (fs) begin m_state = 1; m_h = 0; m_v = VL; end
    end else if (fs && lock_err(m_v) > LW) begin
      m_state = 1; m_h = 0; m_v = VL; m_resync = 1;
    end else begin
      if (fs) m_state = 2;
      advance();
    end
`else
    if (m_state == 0) m_state = 2;
    else advance();
`endif
  endtask

  task automatic compare_all();
    bit de;
    chk("hcnt",  hcnt_ext, m_h);
    chk("vcnt",  vcnt_ext, m_v);
    chk("hctr",  hctr_ext,      in_hw(m_h) ? (m_h - HS) % HM : 0);
    chk("hlbuf", hcnt_ext_lbuf, in_hw(m_h) ? (m_h - HS) / HM : 0);
    chk("vctr",  vctr_ext,      in_vw(m_v) ? (m_v - VS) % VM : 0);
    chk("vlbuf", vcnt_ext_lbuf, in_vw(m_v) ? ((m_v - VS) / VM) % NLB : 0);
    de = m_prev_run && in_hde(m_hp) && in_vde(m_vp);
    chk("hsync",  HSYNC_ext, !(m_prev_run && m_hp < HSY));
    chk("vsync",  VSYNC_ext, !(m_prev_run && m_vp < VSY));
    chk("de",     DE_ext, de);
    chk("mask",   mask_enable_ext, de && !(in_hw(m_hp) && in_vw(m_vp)));
    chk("locked", locked, m_state == 2);
    chk("resync", resync, m_resync);
  endtask

  // One clock: drive at the falling edge, model at the rising edge,
  // sample 1 ns later. An asserted reset is also checked before the edge.
  task automatic step(input bit fs, input bit rst_b);
    @(negedge clk_sys);
    frame_start = fs;
    reset_n     = rst_b;
    fs_prev     = fs;
    if (!rst_b) begin
      #1;
      model_reset();
      compare_all();
    end
    @(posedge clk_sys);
    if (reset_n) model_clock(fs);
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic run_until(input int v, input int h, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_v == v && m_h == h && m_state != 0) begin
        ok = 1;
        return;
      end
      step(0, 1);
    end
  endtask

  initial begin
    bit fs, ok, found;
    int cnt;
    reset_n = 1'b0;
    frame_start = 1'b0;
    fs_prev = 0;
    model_reset();

    repeat (3) step(0, 0);
    step(0, 1);
`ifdef FRAMELOCK_EN
    step(1, 1);
`endif

    // randomized frame_start pulses and occasional resets
    for (int i = 0; i < 6000; i++) begin
      fs = 0;
      if (!fs_prev)
        fs = ($urandom_range(0, 499) == 0) ||
             (m_v == VL + 1 && m_h == 7 && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2999) == 0) begin
        step(0, 0);
        step(0, 0);
      end else begin
        step(fs, 1);
      end
    end

    // reset in the middle of an active line
    if (m_state == 0) step(1, 1);
    run_until(VSY + VBP + 3, HSY + HBP + 10, ok);
    if (!ok) chk("mid_rst_timeout", 0, 1);
    step(0, 0);
    step(0, 0);
    repeat (20) step(0, 1);
`ifdef FRAMELOCK_EN
    step(1, 1);
    // in-window pulse locks
    run_until(VL + 1, 3, ok);
    if (!ok) chk("lock_timeout", 0, 1);
    step(1, 1);
    chk("lock_in", locked, 1);
    // out-of-window pulse forces and drops lock
    run_until(10, 0, ok);
    if (!ok) chk("force_timeout", 0, 1);
    step(1, 1);
    chk("force_resync", resync, 1);
    chk("force_vcnt", vcnt_ext, VL);
    chk("force_unlock", locked, 0);
    step(0, 1);
    chk("resync_one_clk", resync, 0);
`endif

    // raster period
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(0, 1);
      if (hcnt_ext == 0 && vcnt_ext == 0) begin found = 1; break; end
    end
    if (!found) chk("period_start_timeout", 0, 1);
    else begin
      cnt = 0;
      found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step(0, 1);
        cnt++;
        if (hcnt_ext == 0 && vcnt_ext == 0) begin found = 1; break; end
      end
      if (!found) chk("period_end_timeout", 0, 1);
      else chk("period", cnt, FRAME);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
